wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter that sits directly upstream of the register file and is the sole driver of its write port (`ctrl_writeEnable`, `ctrl_writeReg`, `data_writeReg`). It merges two result sources:

- the in-order pipeline writeback, which always has priority;
- the multi-cycle mult/div unit, whose results are held in a 2-entry pending queue until a free write slot appears.

It also exports a busy mask of registers with queued writes, for hazard detection in decode.

## Interface
Parameters:
- `QDEPTH`, default 2: pending mult/div queue depth. Values 1..4 are legal; 2 is the shipped value.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `ctrl_reset` in 1: asynchronous, active-high reset.
- `pipe_we` in 1: pipeline writeback valid this cycle.
- `pipe_reg` in 5: pipeline destination register.
- `pipe_data` in 32: pipeline result.
- `md_valid` in 1: mult/div result offered.
- `md_ready` out 1: arbiter can accept a mult/div result this cycle.
- `md_reg` in 5: mult/div destination register.
- `md_data` in 32: mult/div result.
- `ctrl_writeEnable` out 1: registered write enable to the register file.
- `ctrl_writeReg` out 5: registered write address.
- `data_writeReg` out 32: registered write data.
- `busy_mask` out 32: bit R = 1 while a valid queued entry targets register R.

## Operation
**Queue state**
- FIFO of `QDEPTH` entries; each entry is {valid, reg[4:0], data[31:0]}.
- Occupancy counter `cnt`, 0..QDEPTH, counting occupied slots (valid or squashed).

**Handshake**
- `md_ready = (cnt < QDEPTH)`, decoded from registered `cnt` only.
- Transfer occurs when `md_valid && md_ready`.
- Mult/div holds `md_reg`/`md_data` stable until transfer.

**Slot selection each cycle, in priority order**
1. `pipe_we && pipe_reg != 0`: write the pipeline result.
2. Else, if `cnt > 0`: pop the head. If the head is valid, write it; otherwise no write this cycle.
3. Else, if a transfer occurs and `md_reg != 0`: write the mult/div result directly, bypassing the queue.
4. Else: no write (`ctrl_writeEnable` = 0, `ctrl_writeReg` and `data_writeReg` hold).

**Queue push and discard**
- A transferred result that is not written in this cycle is pushed at the tail.
- A transferred result with `md_reg == 0` is accepted and discarded: no push, no write.

**Squash (pipeline is the younger writer and wins)**
- When the pipeline writes R, every queued entry with reg == R has valid cleared in the same edge.
- A same-cycle mult/div transfer with `md_reg == R` is accepted and discarded.
- Squashed entries still occupy their slot until popped.

**Register 0**
- A write with reg 0 never reaches `ctrl_writeEnable`.
- `pipe_we` with `pipe_reg == 0` is treated as no pipeline write.

**Simultaneous push and pop**
- Both are allowed in one cycle; `cnt` is unchanged.
- A pop and a direct write never happen in the same cycle.

**Busy mask**
- `busy_mask` = OR over valid queued entries of one-hot(reg), computed from registered state.

## Timing
- **Latency:** inputs sampled at edge t appear on `ctrl_*`/`data_writeReg` after edge t; the register file commits at edge t+1.
- **Queued result:** a queued mult/div result is written one cycle after the first cycle without a pipeline write.
- **Reset values:** `ctrl_writeEnable` = 0, `ctrl_writeReg` = 0, `data_writeReg` = 0, `cnt` = 0, all entries invalid, `busy_mask` = 0, `md_ready` = 1.
- **Reset mid-operation:** queued results are lost. The mult/div unit is reset by the same `ctrl_reset`.
- **Full queue:** `md_ready` = 0 for the whole cycle, even if a pop occurs that cycle; it rises the cycle after `cnt` drops.
- **Starvation:** queued entries wait indefinitely under back-to-back pipeline writes; this is accepted behaviour.

## Configuration
`WB_PERF_COUNTERS_EN`:
- **Defined:** adds two output ports, each 16 bits, saturating at 0xFFFF and cleared by `ctrl_reset`.
  - `wb_conflict_cnt`: counts cycles where a transfer occurs and is pushed because of a pipeline write.
  - `wb_squash_cnt`: counts entries (queued plus incoming) squashed by pipeline writes.
- **Undefined:** neither the ports nor the counter logic exist; all other behaviour is identical.

## Test plan
- **Reset:** assert `ctrl_reset` mid-stream with the queue holding 2 entries → all outputs 0 asynchronously, `md_ready` = 1, `busy_mask` = 0.
- **Pipeline write:** `pipe_we` = 1, `pipe_reg` = 5, `pipe_data` = 0xDEADBEEF → next cycle `ctrl_writeEnable` = 1, `ctrl_writeReg` = 5, `data_writeReg` = 0xDEADBEEF. The same stimulus with `pipe_reg` = 0 → `ctrl_writeEnable` = 0.
- **Conflict:** pipeline writes r3 while mult/div offers r7 = 42 → cycle 1 writes r3 and `busy_mask` = 0x80. With no pipeline write next → cycle 2 writes r7 = 42 and `busy_mask` = 0.
- **Full queue:** pipeline writes for 4 consecutive cycles while `md_valid` is held with r8 then r9 → queue fills, `md_ready` = 0, nothing written for r8/r9. After the pipeline goes idle, r8 then r9 are written in order.
- **Squash:** r10 is queued, then the pipeline writes r10 = 1 → `busy_mask` bit 10 clears. The later pop produces no write; the final r10 value is 1.
- **Counters (with `WB_PERF_COUNTERS_EN`):** run the conflict and squash scenarios → `wb_conflict_cnt` = 1 and `wb_squash_cnt` = 1.

Source files
------------

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//
// Writeback arbiter in front of the register file write port. It merges the
// in-order pipeline writeback (always highest priority) with results from the
// multi-cycle mult/div unit. Mult/div results that cannot be written right
// away wait in a small pending queue until a cycle without a pipeline write.
// A busy mask of registers with queued writes is exported for decode hazard
// detection.
//
// Parameters:
//   QDEPTH            pending mult/div queue depth (1..4, default 2)
//
// Ports:
//   clock             single clock, rising edge
//   ctrl_reset        asynchronous, active-high reset
//   pipe_we           pipeline writeback valid this cycle
//   pipe_reg[4:0]     pipeline destination register
//   pipe_data[31:0]   pipeline result
//   md_valid          mult/div result offered
//   md_ready          arbiter accepts a mult/div result this cycle
//   md_reg[4:0]       mult/div destination register
//   md_data[31:0]     mult/div result
//   ctrl_writeEnable  registered register-file write enable
//   ctrl_writeReg     registered register-file write address
//   data_writeReg     registered register-file write data
//   busy_mask[31:0]   bit R set while a valid queued entry targets R
//
// Optional feature (macro WB_PERF_COUNTERS_EN):
//   wb_conflict_cnt   16-bit saturating count of cycles where a transfer
//                     had to be queued because the pipeline was writing
//   wb_squash_cnt     16-bit saturating count of entries (queued and
//                     incoming) squashed by pipeline writes
// ---------------------------------------------------------------------------
module wb_arbiter #(
    parameter int QDEPTH = 2
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_reg,
    input  logic [31:0] pipe_data,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_reg,
    input  logic [31:0] md_data,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
`ifdef WB_PERF_COUNTERS_EN
    output logic [15:0] wb_conflict_cnt,
    output logic [15:0] wb_squash_cnt,
`endif
    output logic [31:0] busy_mask
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] QMAX = CW'(QDEPTH);

    typedef struct packed {
        logic        valid;
        logic [4:0]  rg;
        logic [31:0] data;
    } entry_t;

    // Entry 0 is always the head; pops shift the array down by one.
    entry_t        q     [QDEPTH];
    entry_t        q_n   [QDEPTH];
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [CW-1:0] push_idx;

    logic pipe_wr;
    logic xfer;
    logic pop;
    logic direct;
    logic md_discard;
    logic push;

    logic        wr_en_n;
    logic [4:0]  wr_reg_n;
    logic [31:0] wr_data_n;

    // Handshake: md_valid/md_ready follow strict valid/ready semantics. A
    // result transfers on a rising edge where both are high; md_ready depends
    // only on the registered occupancy (never on md_valid or the current
    // cycle's pop), and the mult/div unit holds md_reg/md_data stable while
    // md_valid is high and no transfer has happened.
    assign md_ready = (cnt < QMAX);
    assign xfer     = md_valid && md_ready;

    // A pipeline write to r0 is no write at all.
    assign pipe_wr  = pipe_we && (pipe_reg != 5'd0);

    // Occupied slots (valid or squashed) are drained only in free cycles.
    assign pop      = !pipe_wr && (cnt != '0);

    // Bypass straight to the write port only when nothing else competes.
    assign direct   = !pipe_wr && (cnt == '0) && xfer && (md_reg != 5'd0);

    // r0 results and results the same-cycle pipeline write overtakes are
    // accepted but thrown away.
    assign md_discard = (md_reg == 5'd0) || (pipe_wr && (md_reg == pipe_reg));

    assign push     = xfer && !direct && !md_discard;

    // When pushing and popping together the tail moves down one slot.
    assign push_idx = pop ? (cnt - CW'(1)) : cnt;

    // ---------------------------------------------------------------------
    // Next queue contents: squash, pop-shift, push.
    // ---------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < QDEPTH; i++) begin
            q_n[i] = q[i];
        end

        // The pipeline is the younger writer: older queued results to the
        // same register must never land after it.
        if (pipe_wr) begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (q[i].rg == pipe_reg) begin
                    q_n[i].valid = 1'b0;
                end
            end
        end

        if (pop) begin
            for (int i = 0; i < QDEPTH - 1; i++) begin
                q_n[i] = q[i + 1];
            end
            q_n[QDEPTH-1] = '0;
        end

        if (push) begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (CW'(i) == push_idx) begin
                    q_n[i].valid = 1'b1;
                    q_n[i].rg    = md_reg;
                    q_n[i].data  = md_data;
                end
            end
        end
    end

    always_comb begin
        cnt_n = cnt;
        if (push && !pop) begin
            cnt_n = cnt + CW'(1);
        end else if (pop && !push) begin
            cnt_n = cnt - CW'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Write slot selection, highest priority first. Address and data hold
    // their previous values in cycles without a write.
    // ---------------------------------------------------------------------
    always_comb begin
        wr_en_n   = 1'b0;
        wr_reg_n  = ctrl_writeReg;
        wr_data_n = data_writeReg;
        if (pipe_wr) begin
            wr_en_n   = 1'b1;
            wr_reg_n  = pipe_reg;
            wr_data_n = pipe_data;
        end else if (pop) begin
            // A squashed head still consumes the slot but writes nothing.
            if (q[0].valid) begin
                wr_en_n   = 1'b1;
                wr_reg_n  = q[0].rg;
                wr_data_n = q[0].data;
            end
        end else if (direct) begin
            wr_en_n   = 1'b1;
            wr_reg_n  = md_reg;
            wr_data_n = md_data;
        end
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            cnt              <= '0;
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= 5'd0;
            data_writeReg    <= 32'd0;
            for (int i = 0; i < QDEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            cnt              <= cnt_n;
            ctrl_writeEnable <= wr_en_n;
            ctrl_writeReg    <= wr_reg_n;
            data_writeReg    <= wr_data_n;
            for (int i = 0; i < QDEPTH; i++) begin
                q[i] <= q_n[i];
            end
        end
    end

    // Slots beyond the occupancy are always cleared, so the mask can scan
    // the whole array.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (q[i].valid) begin
                busy_mask[q[i].rg] = 1'b1;
            end
        end
    end

`ifdef WB_PERF_COUNTERS_EN
    logic [3:0]  squash_inc;
    logic [16:0] conflict_sum;
    logic [16:0] squash_sum;

    always_comb begin
        squash_inc = '0;
        if (pipe_wr) begin
            // Entries already squashed are not counted a second time.
            for (int i = 0; i < QDEPTH; i++) begin
                if (q[i].valid && (q[i].rg == pipe_reg)) begin
                    squash_inc = squash_inc + 4'd1;
                end
            end
            if (xfer && (md_reg == pipe_reg)) begin
                squash_inc = squash_inc + 4'd1;
            end
        end
    end

    assign conflict_sum = {1'b0, wb_conflict_cnt} + {16'd0, (push && pipe_wr)};
    assign squash_sum   = {1'b0, wb_squash_cnt} + {13'd0, squash_inc};

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            wb_conflict_cnt <= 16'd0;
            wb_squash_cnt   <= 16'd0;
        end else begin
            wb_conflict_cnt <= conflict_sum[16] ? 16'hFFFF : conflict_sum[15:0];
            wb_squash_cnt   <= squash_sum[16]   ? 16'hFFFF : squash_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
//
// Directed bench for wb_arbiter (QDEPTH = 2). A vector table covers single
// cycle behaviour and short sequences; hand-written sequences cover the full
// queue and asynchronous reset with a loaded queue. A shadow register file
// records committed writes for end-of-run value checks.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

    logic        clock;
    logic        ctrl_reset;
    logic        pipe_we;
    logic [4:0]  pipe_reg;
    logic [31:0] pipe_data;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_reg;
    logic [31:0] md_data;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [31:0] busy_mask;
`ifdef WB_PERF_COUNTERS_EN
    logic [15:0] wb_conflict_cnt;
    logic [15:0] wb_squash_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] rf_shadow [32];

    wb_arbiter #(.QDEPTH(2)) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .pipe_we          (pipe_we),
        .pipe_reg         (pipe_reg),
        .pipe_data        (pipe_data),
        .md_valid         (md_valid),
        .md_ready         (md_ready),
        .md_reg           (md_reg),
        .md_data          (md_data),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
`ifdef WB_PERF_COUNTERS_EN
        .wb_conflict_cnt  (wb_conflict_cnt),
        .wb_squash_cnt    (wb_squash_cnt),
`endif
        .busy_mask        (busy_mask)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file model: commits whatever the arbiter presents.
    always @(posedge clock) begin
        if (ctrl_writeEnable) begin
            rf_shadow[ctrl_writeReg] <= data_writeReg;
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ewe, input logic [4:0] ereg,
                           input logic [31:0] edata, input logic [31:0] ebusy, input logic erdy);
        chk({tag, ".we"},    {31'd0, ctrl_writeEnable}, {31'd0, ewe});
        chk({tag, ".reg"},   {27'd0, ctrl_writeReg},    {27'd0, ereg});
        chk({tag, ".data"},  data_writeReg,             edata);
        chk({tag, ".busy"},  busy_mask,                 ebusy);
        chk({tag, ".ready"}, {31'd0, md_ready},         {31'd0, erdy});
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic pwe, input logic [4:0] preg, input logic [31:0] pdata,
                         input logic mv, input logic [4:0] mreg, input logic [31:0] mdata);
        pipe_we   = pwe;
        pipe_reg  = preg;
        pipe_data = pdata;
        md_valid  = mv;
        md_reg    = mreg;
        md_data   = mdata;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        pwe;
        logic [4:0]  preg;
        logic [31:0] pdata;
        logic        mv;
        logic [4:0]  mreg;
        logic [31:0] mdata;
        logic        ewe;
        logic [4:0]  ereg;
        logic [31:0] edata;
        logic [31:0] ebusy;
        logic        erdy;
        logic [15:0] econf;
        logic [15:0] esq;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];

    initial begin
        for (int i = 0; i < 32; i++) rf_shadow[i] = 32'd0;

        // pipeline write, then r0 pipeline write (no write, outputs hold)
        tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,  1'b1, 5'd5,  32'hDEADBEEF, 32'h0,   1'b1, 16'd0, 16'd0};
        tbl[1]  = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  32'h0,  1'b0, 5'd5,  32'hDEADBEEF, 32'h0,   1'b1, 16'd0, 16'd0};
        // conflict: r3 from pipeline, r7 queued then written
        tbl[2]  = '{1'b1, 5'd3,  32'h00000033, 1'b1, 5'd7,  32'd42, 1'b1, 5'd3,  32'h00000033, 32'h80,  1'b1, 16'd1, 16'd0};
        tbl[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 5'd7,  32'd42,       32'h0,   1'b1, 16'd1, 16'd0};
        // direct bypass with empty queue, then r0 mult/div result discarded
        tbl[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'hC0, 1'b1, 5'd12, 32'h000000C0, 32'h0,   1'b1, 16'd1, 16'd0};
        tbl[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h5,  1'b0, 5'd12, 32'h000000C0, 32'h0,   1'b1, 16'd1, 16'd0};
        // squash: r10 queued, pipeline writes r10=1, squashed pop writes nothing
        tbl[6]  = '{1'b1, 5'd1,  32'h1,        1'b1, 5'd10, 32'hA,  1'b1, 5'd1,  32'h1,        32'h400, 1'b1, 16'd2, 16'd0};
        tbl[7]  = '{1'b1, 5'd10, 32'h1,        1'b0, 5'd0,  32'h0,  1'b1, 5'd10, 32'h1,        32'h0,   1'b1, 16'd2, 16'd1};
        tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd10, 32'h1,        32'h0,   1'b1, 16'd2, 16'd1};
        tbl[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd10, 32'h1,        32'h0,   1'b1, 16'd2, 16'd1};
        // same-cycle incoming result to the pipeline's register is discarded
        tbl[10] = '{1'b1, 5'd4,  32'h4,        1'b1, 5'd4,  32'h44, 1'b1, 5'd4,  32'h4,        32'h0,   1'b1, 16'd2, 16'd2};
        tbl[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd4,  32'h4,        32'h0,   1'b1, 16'd2, 16'd2};
        // simultaneous push and pop keeps occupancy at one
        tbl[12] = '{1'b1, 5'd2,  32'h2,        1'b1, 5'd6,  32'h66, 1'b1, 5'd2,  32'h2,        32'h40,  1'b1, 16'd3, 16'd2};
        tbl[13] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h99, 1'b1, 5'd6,  32'h66,       32'h200, 1'b1, 16'd3, 16'd2};
        tbl[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 5'd9,  32'h99,       32'h0,   1'b1, 16'd3, 16'd2};
    end

    // ---------------- test sequence ----------------
    initial begin
        ctrl_reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        step();
        chk_out("reset", 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
        ctrl_reset = 1'b0;
        step();

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].pwe, tbl[i].preg, tbl[i].pdata, tbl[i].mv, tbl[i].mreg, tbl[i].mdata);
            step();
            chk_out($sformatf("vec%0d", i), tbl[i].ewe, tbl[i].ereg, tbl[i].edata, tbl[i].ebusy, tbl[i].erdy);
`ifdef WB_PERF_COUNTERS_EN
            chk($sformatf("vec%0d.conf_cnt", i), {16'd0, wb_conflict_cnt}, {16'd0, tbl[i].econf});
            chk($sformatf("vec%0d.squash_cnt", i), {16'd0, wb_squash_cnt}, {16'd0, tbl[i].esq});
`endif
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        chk("rf_r10_final", rf_shadow[10], 32'h1);
        chk("rf_r7_final",  rf_shadow[7],  32'd42);
        chk("rf_r12_final", rf_shadow[12], 32'hC0);

        // ---- full queue: four pipeline writes, mult/div offers r8, r9, r11 ----
        drive(1'b1, 5'd20, 32'd20, 1'b1, 5'd8, 32'h88);
        step();
        chk_out("full_a", 1'b1, 5'd20, 32'd20, 32'h100, 1'b1);
        drive(1'b1, 5'd21, 32'd21, 1'b1, 5'd9, 32'h99);
        step();
        chk_out("full_b", 1'b1, 5'd21, 32'd21, 32'h300, 1'b0);
        drive(1'b1, 5'd22, 32'd22, 1'b1, 5'd11, 32'hBB);
        step();
        chk_out("full_c", 1'b1, 5'd22, 32'd22, 32'h300, 1'b0);
        drive(1'b1, 5'd23, 32'd23, 1'b1, 5'd11, 32'hBB);
        step();
        chk_out("full_d", 1'b1, 5'd23, 32'd23, 32'h300, 1'b0);
        // pipeline idle: head pops this cycle but ready stays low until cnt drops
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'hBB);
        #3;
        chk("full_e.ready_pre", {31'd0, md_ready}, 32'd0);
        step();
        chk_out("full_e", 1'b1, 5'd8, 32'h88, 32'h200, 1'b1);
        step();
        chk_out("full_f", 1'b1, 5'd9, 32'h99, 32'h800, 1'b1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        chk_out("full_g", 1'b1, 5'd11, 32'hBB, 32'h0, 1'b1);
        step();
        chk_out("full_h", 1'b0, 5'd11, 32'hBB, 32'h0, 1'b1);
        chk("rf_r8",  rf_shadow[8],  32'h88);
        chk("rf_r9",  rf_shadow[9],  32'h99);
        chk("rf_r11", rf_shadow[11], 32'hBB);

        // ---- asynchronous reset with two entries queued ----
        drive(1'b1, 5'd13, 32'hD, 1'b1, 5'd14, 32'hE);
        step();
        drive(1'b1, 5'd15, 32'hF, 1'b1, 5'd16, 32'h10);
        step();
        chk_out("pre_rst", 1'b1, 5'd15, 32'hF, 32'h14000, 1'b0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #2;
        ctrl_reset = 1'b1;
        #1;
        chk_out("rst_async", 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
`ifdef WB_PERF_COUNTERS_EN
        chk("rst_async.conf_cnt",   {16'd0, wb_conflict_cnt}, 32'd0);
        chk("rst_async.squash_cnt", {16'd0, wb_squash_cnt},   32'd0);
`endif
        step();
        ctrl_reset = 1'b0;
        step();
        chk_out("post_rst", 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
        step();
        chk_out("post_rst2", 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
